// File: rtl/adder_seq_ctrl.sv
// Nibble-serial wide adder: one 4-bit adder, carry kept in a flop.
// Ports: clk, rst_n, start, a_in, b_in, c_in -> busy, done, sum_out, c_out.

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module adder_seq_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum_out,
  output logic         c_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic [3:0]     nib_s;
  logic           nib_c;
  logic [W-1:0]   res_nx;
  logic           last;

  adder_4bit u_add (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_c)
  );

  // New nibble enters at the top; after NIBBLES shifts
  // nibble 0 has reached the bottom.
  assign res_nx = W'({nib_s, res_q} >> 4);
  assign last   = (idx_q == IW'(NIBBLES - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a_in;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = res_nx;
        carry_d = nib_c;
        idx_d   = idx_q + 1'b1;
        busy_d  = 1'b1;
        if (last) begin
          state_d = DONE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_nx;
          cout_d  = nib_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign c_out   = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (NIBBLES=4 and NIBBLES=1).
// Expected sums are queued at launch and popped at done.

module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, c_in;
  logic [15:0] a_in, b_in;
  logic        busy, done, c_out;
  logic [15:0] sum_out;

  logic        start1, c1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.NIBBLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .c_in    (c_in),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .c_out   (c_out)
  );

  adder_seq_ctrl #(.NIBBLES(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
    .a_in    (a1),
    .b_in    (b1),
    .c_in    (c1),
    .busy    (busy1),
    .done    (done1),
    .sum_out (sum1),
    .c_out   (cout1)
  );

  logic [16:0] sb[$];
  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic c);
    a_in  = a;
    b_in  = b;
    c_in  = c;
    start = 1'b1;
    sb.push_back({1'b0, a} + {1'b0, b} + 17'(c));
  endtask

  task automatic check_result(input string tag);
    logic [16:0] e;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      nvec++;
      nbad++;
      $error("FAIL %s_sb: got done want no done", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(sum_out), 32'(e[15:0]));
      chk({tag, "_cout"}, 32'(c_out), 32'(e[16]));
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic c);
    launch(a, b, c);
    tick();
    start = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
    c_in  = 1'($urandom);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s_nodone%0d", tag, k), 32'(done), 32'd0);
      tick();
    end
    check_result(tag);
    tick();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [16:0] e1;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    c_in   = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    c1     = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op("basic", 16'h1234, 16'h4321, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
    run_op("allone", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("mixed", 16'h9A7C, 16'h65B3, 1'b1);

    // start pulse during RUN must be ignored
    launch(16'h0F0F, 16'h0101, 1'b0);
    tick();
    start = 1'b0;
    chk("ign_busy1", 32'(busy), 32'd1);
    tick();
    a_in  = 16'hAAAA;
    start = 1'b1;
    chk("ign_busy2", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    tick();
    tick();
    check_result("ign");
    for (int k = 6; k <= 9; k++) begin
      tick();
      chk($sformatf("ign_nodone%0d", k), 32'(done), 32'd0);
      chk($sformatf("ign_nobusy%0d", k), 32'(busy), 32'd0);
    end

    // reset in the middle of an operation
    launch(16'h1234, 16'h1111, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mrst_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_sum", 32'(sum_out), 32'd0);
    chk("mrst_cout", 32'(c_out), 32'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mrst_nodone%0d", k), 32'(done), 32'd0);
    end
    run_op("postrst", 16'h0003, 16'h0004, 1'b0);

    // back-to-back accept in the DONE cycle
    launch(16'h0001, 16'h0001, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_result("b2b1");
    launch(16'h8000, 16'h8000, 1'b0);
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    for (int k = 6; k <= 9; k++) begin
      chk($sformatf("b2b_hold%0d", k), 32'(sum_out), 32'h0002);
      chk($sformatf("b2b_nodone%0d", k), 32'(done), 32'd0);
      if (k < 9) tick();
    end
    tick();
    check_result("b2b2");
    tick();
    chk("b2b_pulse", 32'(done), 32'd0);

    // single-nibble instance
    a1     = 4'hF;
    b1     = 4'h1;
    c1     = 1'b0;
    start1 = 1'b1;
    sb.push_back(17'({1'b0, a1} + {1'b0, b1} + 5'(c1)));
    tick();
    start1 = 1'b0;
    chk("n1_busy", 32'(busy1), 32'd1);
    chk("n1_nodone", 32'(done1), 32'd0);
    tick();
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_busy2", 32'(busy1), 32'd0);
    if (sb.size() == 0) begin
      nvec++;
      nbad++;
      $error("FAIL n1_sb: got empty want entry");
    end else begin
      e1 = sb.pop_front();
      chk("n1_sum", 32'(sum1), 32'(e1[3:0]));
      chk("n1_cout", 32'(cout1), 32'(e1[4]));
    end
    tick();
    chk("n1_pulse", 32'(done1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
